mem_access_unit: RTL and testbench

- Parametrised successor to the single-cycle data-memory stage.
- Owns a DATA_W x 2^ADDR_W data memory.
- Core side: request/done handshake with configurable wait states, word or byte access size, and sign- or zero-extended loads into an OUT_W result register.
- Debug/export side: a second access path with an explicit acknowledge, used to preload and inspect memory.

---
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data memory with a wait-stated core port (word/byte, sign/zero-extended loads)
// and an export port for preloading and inspecting memory between core accesses.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int OUT_W   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  data_out,
  input  logic              exp_en,
  input  logic              exp_MR,
  input  logic              exp_MW,
  input  logic [ADDR_W-1:0] exp_address,
  input  logic [DATA_W-1:0] exp_data,
  output logic [DATA_W-1:0] exp_out,
  output logic              exp_ack
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic              we;
    logic              size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  req_t              cur;
  logic              accept, finish, exp_go;
  logic [DATA_W-1:0] rd_word;
  logic [OUT_W-1:0]  ld_val;

  assign busy    = (state == WAIT);
  // Accepting a core request already requires no export strobe, so exports never collide with it.
  assign exp_go  = (state == IDLE) && (exp_MR || exp_MW);
  assign rd_word = mem[cur.addr];

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (req && !exp_en && !exp_MR && !exp_MW) begin
        accept  = 1'b1;
        state_n = WAIT;
      end
      WAIT: if (cnt == '0) begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ld_val = '0;
    if (cur.size) ld_val = cur.sign ? OUT_W'($signed(rd_word[7:0])) : OUT_W'(rd_word[7:0]);
    else          ld_val = cur.sign ? OUT_W'($signed(rd_word))      : OUT_W'(rd_word);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= '0;
      done     <= 1'b0;
      exp_ack  <= 1'b0;
      data_out <= '0;
      exp_out  <= '0;
    end else begin
      state   <= state_n;
      done    <= finish;
      exp_ack <= exp_go;
      if (accept) begin
        cur <= '{we: we, size: size, sign: sign, addr: addr, wdata: wdata};
        cnt <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish && !cur.we) data_out <= ld_val;
      if (exp_go && exp_MR)  exp_out  <= mem[exp_address];
    end
  end

  // Contents survive reset; writes are suppressed while reset is high so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (finish && cur.we)
        mem[cur.addr] <= cur.size ? {rd_word[DATA_W-1:8], cur.wdata[7:0]} : cur.wdata;
      if (exp_go && exp_MW)
        mem[exp_address] <= exp_data;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plan scenarios plus randomized export/core traffic against an array-based memory model.
module tb_mem_access_unit;
  logic        clk = 0, reset = 1;
  logic        req = 0, we = 0, size = 0, sign = 0;
  logic [10:0] addr = 0;
  logic [15:0] wdata = 0;
  logic        busy, done;
  logic [31:0] data_out;
  logic        exp_en = 0, exp_MR = 0, exp_MW = 0;
  logic [10:0] exp_address = 0;
  logic [15:0] exp_data = 0;
  logic [15:0] exp_out;
  logic        exp_ack;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .data_out(data_out),
    .exp_en(exp_en), .exp_MR(exp_MR), .exp_MW(exp_MW), .exp_address(exp_address),
    .exp_data(exp_data), .exp_out(exp_out), .exp_ack(exp_ack)
  );

  always #5 clk = ~clk;

  int          cyc = 0, last_done = 0;
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m [2048];
  logic [31:0] dout = 0;
  logic [15:0] eo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] w, input bit sz, input bit sg);
    int unsigned v;
    if (sz) begin
      v = w % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = w;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic exp_op(input bit mr, input bit mw, input int a, input logic [15:0] d);
    exp_MR = mr; exp_MW = mw; exp_address = a[10:0]; exp_data = d;
    step();
    exp_MR = 0; exp_MW = 0;
    chk("exp_ack", exp_ack, 1);
    if (mr) eo = m[a];
    chk("exp_out", exp_out, eo);
    if (mw) m[a] = d;
  endtask

  task automatic core_op(input bit w, input bit sz, input bit sg, input int a,
                         input logic [15:0] wd, input bit b2b);
    req = 1; we = w; size = sz; sign = sg; addr = a[10:0]; wdata = wd;
    step();
    req = 0;
    chk("busy_c0", busy, 1);
    step();
    chk("busy_c1", busy, 1);
    chk("done_early", done, 0);
    step();
    chk("busy_end", busy, 0);
    chk("done", done, 1);
    if (w) m[a] = sz ? ((m[a] & 16'hFF00) | (wd & 16'h00FF)) : wd;
    else   dout = ext(m[a], sz, sg);
    chk("data_out", data_out, dout);
    if (b2b) chk("done_spacing", cyc - last_done, 3);
    last_done = cyc;
  endtask

  initial begin
    // Reset state
    reset = 1; step(); step();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dout", data_out, 0);
    chk("rst_eout", exp_out, 0); chk("rst_ack", exp_ack, 0);
    reset = 0; step();

    // 1: export write then signed/unsigned word loads
    exp_op(0, 1, 5, 16'h8001);
    core_op(0, 0, 1, 5, 0, 0);
    chk("t1_signed", data_out, 32'hFFFF_8001);
    core_op(0, 0, 0, 5, 0, 1);
    chk("t1_unsigned", data_out, 32'h0000_8001);

    // 2: byte store keeps upper bits, byte loads
    exp_op(0, 1, 7, 16'h1234);
    core_op(1, 1, 0, 7, 16'hAB80, 0);
    chk("t2_store_keeps_dout", data_out, 32'h0000_8001);
    core_op(0, 1, 1, 7, 0, 1);
    chk("t2_byte_signed", data_out, 32'hFFFF_FF80);
    core_op(0, 0, 0, 7, 0, 1);
    chk("t2_word_after_rmw", data_out, 32'h0000_1280);
    core_op(0, 1, 0, 7, 0, 1);
    chk("t2_byte_unsigned", data_out, 32'h0000_0080);

    // 3: back-to-back store then load of the same address
    core_op(1, 0, 0, 11, 16'hC3A5, 1);
    core_op(0, 0, 0, 11, 0, 1);
    chk("t3_b2b_load", data_out, 32'h0000_C3A5);

    // 4: export asserted during a core access
    req = 1; we = 0; size = 0; sign = 0; addr = 5;
    step();
    req = 0; exp_en = 1; exp_MR = 1; exp_address = 5;
    step();
    chk("t4_busy", busy, 1); chk("t4_no_ack_busy", exp_ack, 0);
    step();
    chk("t4_done", done, 1); chk("t4_no_ack_done", exp_ack, 0);
    dout = ext(m[5], 0, 0);
    chk("t4_dout", data_out, dout);
    step();
    chk("t4_ack", exp_ack, 1); chk("t4_exp_out", exp_out, 16'h8001);
    exp_MR = 0; eo = 16'h8001;
    req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_blocked_busy", busy, 0);
    end
    req = 0; exp_en = 0;
    step();
    chk("t4_blocked_done", done, 0);
    // pending export strobe wins over a core request
    req = 1; addr = 5; we = 0; exp_MR = 1; exp_address = 5;
    step();
    chk("t4_pend_busy", busy, 0); chk("t4_pend_ack", exp_ack, 1);
    exp_MR = 0;
    step();
    chk("t4_pend_accept", busy, 1);
    req = 0;
    step(); step();
    chk("t4_pend_done", done, 1); chk("t4_pend_dout", data_out, dout);

    // 5: reset abandons an in-flight store
    exp_op(0, 1, 9, 16'h0F0F);
    req = 1; we = 1; size = 0; addr = 9; wdata = 16'hAAAA;
    step();
    req = 0;
    step();
    chk("t5_busy2", busy, 1);
    reset = 1;
    step();
    reset = 0; dout = 0; eo = 0;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_dout", data_out, 0);
    step();
    chk("t5_no_done", done, 0);
    exp_op(1, 0, 9, 0);
    chk("t5_mem_kept", exp_out, 16'h0F0F);

    // 6: export read+write returns old contents
    exp_op(0, 1, 3, 16'h5555);
    exp_op(1, 1, 3, 16'h6666);
    chk("t6_rbw", exp_out, 16'h5555);
    exp_op(1, 0, 3, 0);
    chk("t6_new", exp_out, 16'h6666);

    // Random traffic over a preloaded window
    for (int a = 16; a < 32; a++) exp_op(0, 1, a, 16'($urandom));
    begin
      bit prev_core = 0;
      for (int i = 0; i < 80; i++) begin
        int k, a;
        k = $urandom_range(0, 5);
        a = $urandom_range(16, 31);
        case (k)
          0: begin exp_op(0, 1, a, 16'($urandom)); prev_core = 0; end
          1: begin exp_op(1, 0, a, 0);             prev_core = 0; end
          2: begin exp_op(1, 1, a, 16'($urandom)); prev_core = 0; end
          default: begin
            core_op(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), prev_core);
            prev_core = 1;
          end
        endcase
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
